// File: rtl/weight_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : weight_loader_pkg
// Brief   : Loader state encoding and per-layer weight depths shared with the
//           controller-side top.
// Revision: 1.0 - initial release
// ============================================================================
package weight_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_FLUSH    = 3'd2,
        ST_DONE     = 3'd3,
        ST_WAIT_LOW = 3'd4
    } loader_state_t;

    localparam int c_depth_conv1 = 150;    // 6 kernels x 5x5
    localparam int c_depth_conv2 = 2400;   // 16 x 6 x 5x5
    localparam int c_depth_conv3 = 12800;
    localparam int c_depth_fc1   = 10080;  // 120 x 84
    localparam int c_depth_fc2   = 840;    // 84 x 10

    // Address width for a given depth; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_addr_counter.sv
`default_nettype none
// ============================================================================
// Module  : load_addr_counter
// Brief   : Write-address counter with clear, enable and terminal flag at
//           DEPTH-1.
// Revision: 1.0 - initial release
// ============================================================================
module load_addr_counter
    import weight_loader_pkg::*;
#(
    parameter int DEPTH  = 150,
    parameter int ADDR_W = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_clear,
    input  logic              i_enable,
    output logic [ADDR_W-1:0] o_count,
    output logic              o_terminal
);

    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + ADDR_W'(1);
        end
    end

    assign o_count    = r_count;
    assign o_terminal = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/weight_loader.sv
`default_nettype none
// ============================================================================
// Module  : weight_loader
// Brief   : Start/done responder that streams DEPTH words from a valid/ready
//           source into a weight register file write port.
// Revision: 1.0 - initial release
// ============================================================================
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 150,
    parameter int ADDR_W = addr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    loader_state_t     r_state;
    loader_state_t     w_next_state;
    logic              w_accept;
    logic              w_terminal;
    logic [ADDR_W-1:0] w_count;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    assign in_ready = (r_state == ST_LOAD);
    assign w_accept = in_valid && (r_state == ST_LOAD);

    // Enable stops at the terminal word so the count never wraps.
    load_addr_counter #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_addr_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_clear    (r_state != ST_LOAD),
        .i_enable   (w_accept && !w_terminal),
        .o_count    (w_count),
        .o_terminal (w_terminal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A falling start aborts LOAD even on the final accept; that word is still written.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                busy = 1'b1;
                if (!start)                     w_next_state = ST_IDLE;
                else if (w_accept && w_terminal) w_next_state = ST_FLUSH;
            end
            ST_FLUSH: begin
                busy         = 1'b1;
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!start) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_wr_addr <= w_count;
                r_wr_data <= in_data;
            end
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_weight_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_weight_loader
// Brief   : Self-checking bench for weight_loader (DEPTH=4 and DEPTH=1).
// Revision: 1.0 - initial release
// ============================================================================
module tb_weight_loader;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start, in_valid;
    logic [15:0] in_data;
    logic        in_ready, wr_en, busy, done;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;

    logic        s1_start, s1_valid;
    logic [15:0] s1_data;
    logic        s1_ready, s1_wr_en, s1_busy, s1_done;
    logic [0:0]  s1_addr;
    logic [15:0] s1_wr_data;

    weight_loader #(.DATA_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done)
    );

    weight_loader #(.DATA_W(16), .DEPTH(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(s1_start), .in_valid(s1_valid),
        .in_data(s1_data), .in_ready(s1_ready), .wr_en(s1_wr_en), .wr_addr(s1_addr),
        .wr_data(s1_wr_data), .busy(s1_busy), .done(s1_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Transaction-level reference: words taken this load, cycles since the final word.
    bit          m_active;
    int          m_words;
    int          m_tail;
    bit          m_wr_en;
    int          m_addr;
    logic [15:0] m_data;

    int wr_log[$];
    int done_cnt;

    typedef struct {
        bit          s;
        bit          v;
        logic [15:0] d;
        bit          rdy;
        bit          we;
        logic [1:0]  addr;
        logic [15:0] wd;
        bit          bsy;
        bit          dn;
    } vec_t;

    vec_t tbl[8];

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_words  = 0;
        m_tail   = -1;
        m_wr_en  = 1'b0;
        m_addr   = 0;
        m_data   = 16'h0;
    endtask

    task automatic model_step(input bit s, input bit v, input logic [15:0] d);
        bit acc;
        acc     = m_active && v;
        m_wr_en = acc;
        if (acc) begin
            m_addr = m_words;
            m_data = d;
            m_words++;
        end
        if (m_active) begin
            if (!s) begin
                m_active = 1'b0;
                m_words  = 0;
            end else if (m_words == DEPTH) begin
                m_active = 1'b0;
                m_words  = 0;
                m_tail   = 0;
            end
        end else if (m_tail >= 0) begin
            if (m_tail < 2)  m_tail++;
            else if (!s)     m_tail = -1;
        end else if (s) begin
            m_active = 1'b1;
            m_words  = 0;
        end
    endtask

    task automatic compare_model(input string name);
        logic [19:0] got, exp;
        got = {in_ready, busy, done, wr_en, wr_data};
        exp = {m_active, (m_active || m_tail == 0), (m_tail == 1), m_wr_en, m_data};
        check_eq(name, 32'(got), 32'(exp));
        if (m_wr_en) check_eq({name, " addr"}, 32'(wr_addr), 32'(m_addr));
    endtask

    task automatic step(input bit s, input bit v, input logic [15:0] d, input string name);
        start    = s;
        in_valid = v;
        in_data  = d;
        model_step(s, v, d);
        @(posedge clk);
        #1;
        compare_model(name);
        if (wr_en) wr_log.push_back(int'(wr_addr));
        if (done)  done_cnt++;
    endtask

    task automatic run_load(input logic [15:0] base, input string name);
        step(1'b1, 1'b0, 16'h0, name);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b1, base + 16'(i), name);
        step(1'b1, 1'b0, 16'h0, name);
        step(1'b1, 1'b0, 16'h0, name);
    endtask

    function automatic logic [31:0] pack_log();
        logic [31:0] p;
        p = '0;
        foreach (wr_log[i]) p = (p << 4) | 32'(wr_log[i]);
        return p;
    endfunction

    task automatic clear_log();
        wr_log.delete();
        done_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b1, 16'h00A0, 1'b1, 1'b0, 2'd0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 16'h00A1, 1'b1, 1'b1, 2'd0, 16'h00A1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 16'h00A2, 1'b1, 1'b1, 2'd1, 16'h00A2, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 16'h00A3, 1'b1, 1'b1, 2'd2, 16'h00A3, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 16'h00A4, 1'b0, 1'b1, 2'd3, 16'h00A4, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 16'h00FF, 1'b0, 1'b0, 2'd0, 16'h00A4, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b1, 16'h00FF, 1'b0, 1'b0, 2'd0, 16'h00A4, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 2'd0, 16'h00A4, 1'b0, 1'b0};

        start = 1'b0; in_valid = 1'b0; in_data = 16'h0;
        s1_start = 1'b0; s1_valid = 1'b0; s1_data = 16'h0;
        model_reset();
        clear_log();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset outputs", 32'({in_ready, wr_en, busy, done, wr_addr, wr_data}), 32'h0);
        check_eq("reset outputs d1", 32'({s1_ready, s1_wr_en, s1_busy, s1_done, s1_addr, s1_wr_data}), 32'h0);
        reset_n = 1'b1;

        // DEPTH=1 single word
        s1_start = 1'b1; s1_valid = 1'b1; s1_data = 16'h0055;
        step(1'b0, 1'b0, 16'h0, "idle");
        check_eq("d1 load", 32'({s1_ready, s1_wr_en, s1_busy, s1_done}), 32'b1010);
        step(1'b0, 1'b0, 16'h0, "idle");
        check_eq("d1 write", 32'({s1_ready, s1_wr_en, s1_busy, s1_done, s1_addr, s1_wr_data}),
                 32'({4'b0110, 1'b0, 16'h0055}));
        s1_valid = 1'b0;
        step(1'b0, 1'b0, 16'h0, "idle");
        check_eq("d1 done", 32'({s1_ready, s1_wr_en, s1_busy, s1_done}), 32'b0001);
        s1_start = 1'b0;
        step(1'b0, 1'b0, 16'h0, "idle");
        step(1'b0, 1'b0, 16'h0, "idle");
        check_eq("d1 idle", 32'({s1_ready, s1_wr_en, s1_busy, s1_done}), 32'b0000);

        // Full load with in_valid held high, table-driven
        for (int i = 0; i < 8; i++) begin
            start    = tbl[i].s;
            in_valid = tbl[i].v;
            in_data  = tbl[i].d;
            model_step(tbl[i].s, tbl[i].v, tbl[i].d);
            @(posedge clk);
            #1;
            check_eq($sformatf("table row %0d", i),
                     32'({in_ready, wr_en, busy, done, wr_data}),
                     32'({tbl[i].rdy, tbl[i].we, tbl[i].bsy, tbl[i].dn, tbl[i].wd}));
            if (tbl[i].we)
                check_eq($sformatf("table row %0d addr", i), 32'(wr_addr), 32'(tbl[i].addr));
        end

        // in_valid toggling
        clear_log();
        step(1'b1, 1'b0, 16'h0, "toggle");
        for (int i = 0; i < 10; i++) step(1'b1, (i % 2) == 0, 16'h00B0 + 16'(i), "toggle");
        step(1'b0, 1'b0, 16'h0, "toggle");
        check_eq("toggle addrs", pack_log(), 32'h0123);
        check_eq("toggle nwrites", 32'(wr_log.size()), 32'd4);
        check_eq("toggle dones", 32'(done_cnt), 32'd1);

        // start held high after done, then re-armed
        clear_log();
        run_load(16'h00C0, "retrig");
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h00EE, "retrig hold");
        step(1'b0, 1'b0, 16'h0, "retrig low");
        run_load(16'h00C8, "retrig");
        step(1'b0, 1'b0, 16'h0, "retrig");
        check_eq("retrig addrs", pack_log(), 32'h01230123);
        check_eq("retrig nwrites", 32'(wr_log.size()), 32'd8);
        check_eq("retrig dones", 32'(done_cnt), 32'd2);

        // Abort after two accepts, then restart
        clear_log();
        step(1'b1, 1'b0, 16'h0, "abort");
        step(1'b1, 1'b1, 16'h00D0, "abort");
        step(1'b1, 1'b1, 16'h00D1, "abort");
        step(1'b0, 1'b0, 16'h0, "abort");
        check_eq("abort busy", 32'(busy), 32'd0);
        step(1'b0, 1'b0, 16'h0, "abort");
        check_eq("abort addrs", pack_log(), 32'h01);
        check_eq("abort dones", 32'(done_cnt), 32'd0);
        run_load(16'h00E0, "restart");
        step(1'b0, 1'b0, 16'h0, "restart");
        check_eq("restart addrs", pack_log(), 32'h010123);
        check_eq("restart dones", 32'(done_cnt), 32'd1);

        // Asynchronous reset in the middle of LOAD
        step(1'b1, 1'b0, 16'h0, "areset");
        step(1'b1, 1'b1, 16'h00F0, "areset");
        step(1'b1, 1'b1, 16'h00F1, "areset");
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async reset", 32'({in_ready, wr_en, busy, done, wr_addr, wr_data}), 32'h0);
        model_reset();
        start = 1'b0; in_valid = 1'b0;
        #1;
        reset_n = 1'b1;
        step(1'b0, 1'b1, 16'h0, "post reset");
        step(1'b0, 1'b1, 16'h0, "post reset");
        check_eq("post reset ready", 32'(in_ready), 32'd0);

        // Randomized traffic against the reference
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 94, $urandom_range(0, 99) < 70, 16'($urandom), "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Responder end of the controller start/done handshake.
- Accepts the controller's level-held load command (e.g. conv_weight1, fc_weight2) and streams DEPTH words from a valid/ready source into a weight register file via an address-generated write port.
- Returns a single-cycle done pulse to the controller, then waits for the command level to drop before it can re-arm.
- One instance per weight set (conv 1-3, FC 1-2).

Parameters:
- DATA_W, 16, width of one weight word.
- DEPTH, 150, number of words per load (6 kernels x 5x5 for conv layer 1).
- ADDR_W, $clog2(DEPTH), write-address width; minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  load command level from controller; held high for the whole controller state.
- in_valid  input  1  source word valid.
- in_data  input  DATA_W  source word.
- in_ready  output  1  loader can accept a word this cycle.
- wr_en  output  1  registered write strobe to the weight register file.
- wr_addr  output  ADDR_W  registered write address.
- wr_data  output  DATA_W  registered write data.
- busy  output  1  high in LOAD or FLUSH.
- done  output  1  one-cycle completion pulse to controller.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, count=0; in_ready, wr_en, busy and done are 0; wr_addr and wr_data are 0.
- States: IDLE, LOAD, FLUSH, DONE, WAIT_LOW (Moore outputs except in_ready, as noted).
- IDLE:
  - start=1 -> LOAD on the next edge, count cleared to 0.
  - start=0 -> stay in IDLE.
- LOAD:
  - in_ready=1 combinationally from the state.
  - Accept occurs when in_valid & in_ready.
  - On each accept: next cycle wr_en=1, wr_addr=count, wr_data=in_data; count increments.
  - Accept with count==DEPTH-1 -> FLUSH. No further accepts.
- FLUSH: in_ready=0; wr_en=1 for the last word (addr DEPTH-1). -> DONE unconditionally.
- DONE: done=1 for exactly one cycle; wr_en=0. -> WAIT_LOW.
- WAIT_LOW: in_ready=0; start=0 -> IDLE. Prevents re-trigger while the controller is still leaving its state (the controller drops start one cycle after sampling done).
- Latency:
  - First write strobe is 1 cycle after the first accept.
  - done is 1 cycle after the last write strobe.
  - With in_valid held high, minimum load time from start rise to done is DEPTH+2 cycles.
- Write port: wr_en is a one-cycle strobe per accepted word. wr_addr is strictly sequential 0..DEPTH-1 with no gaps or repeats.
- in_valid=0 during LOAD: no accept, wr_en=0 next cycle, count holds.
- Abort: start falls during LOAD -> IDLE next edge.
  - A word accepted in that same cycle is still written.
  - count is cleared and no done is issued.
  - The next start restarts at address 0.
- start falling in FLUSH or DONE is ignored; the sequence completes, done still pulses, then WAIT_LOW exits immediately.
- DEPTH=1: first accept goes straight to FLUSH.
- count width is ADDR_W. It never wraps, because the LOAD exit at DEPTH-1 precedes overflow.
- in_data is sampled only on accept. wr_data holds its last value when wr_en=0.

Decomposition:
- Shared package holds:
  - loader state encoding (IDLE=0, LOAD=1, FLUSH=2, DONE=3, WAIT_LOW=4, 3-bit)
  - per-layer DEPTH constants (CONV1=150, CONV2=2400, CONV3=12800, FC1, FC2), so the controller-side top and the loaders agree.
- One natural sub-module, load_addr_counter: an ADDR_W counter with clear, enable and a terminal-count flag at DEPTH-1.

Test Plan:
- DEPTH=4, start high, in_valid always 1, data 0xA1..0xA4:
  - in_ready high for 4 cycles;
  - wr_en on 4 consecutive cycles at addr 0,1,2,3 with data A1..A4;
  - done exactly 1 cycle, 6 cycles after start rose.
- DEPTH=4, in_valid toggling 1,0,1,0,...: writes to addr 0..3 with no gaps/repeats; count holds on idle cycles; single done after the 4th write.
- Start held high 3 cycles after done, then low, then high again: no second load while high; after the fall, the new rise reloads from addr 0 and a second done occurs.
- Start dropped after 2 accepts: third address never written, no done, busy=0 next cycle. Restart writes addr 0..3 and done pulses once.
- reset_n asserted low in the middle of LOAD: all outputs zero immediately, independent of clk. After release with start low, state stays IDLE and in_ready=0.
- DEPTH=1, single word 0x55: wr_en at addr 0 with data 0x55, done on the following cycle.
